// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: FSM state encoding, requester port indices and timeout-counter sizing shared by the arbiter files
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;
  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core (c_*), DMA (d_*) and memory (mem_*) buses; slave = arbiter side, master = requesters/memory side
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req, c_we, c_ack, c_err;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output c_rdata, c_ack, c_err, d_rdata, d_ack, d_err, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  c_rdata, c_ack, c_err, d_rdata, d_ack, d_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way picker (req0, req1, last, fixed -> grant, valid); a tie goes to port 0 when fixed, else to the port not granted last
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic fixed,
  output logic grant,
  output logic valid
);
  assign valid = req0 | req1;
  assign grant = (req0 && req1) ? (fixed ? PORT_CORE : ~last) : req1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port (bus.mem_*) between core (bus.c_*) and DMA (bus.d_*); clk, async active-low rst, busy/owner status out
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                owner
);
  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  state_e        state_q, state_d;
  logic          owner_q, owner_d, last_q, last_d, we_q, we_d, mem_req_q, mem_req_d;
  logic          c_ack_q, c_ack_d, c_err_q, c_err_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant, valid, timeout, finish;
  logic [DW-1:0] fin_rdata;
  rr_pick2 u_pick (
    .req0  (bus.c_req),
    .req1  (bus.d_req),
    .last  (last_q),
    .fixed (FIXED_PRIO != 0),
    .grant (grant),
    .valid (valid)
  );
  assign timeout   = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !bus.mem_ready;
  assign finish    = bus.mem_ready || timeout;
  assign fin_rdata = bus.mem_ready ? bus.mem_rdata : '0;
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    c_ack_d   = 1'b0;
    c_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (valid) begin
        state_d   = ST_ACCESS;
        owner_d   = grant;
        we_d      = grant ? bus.d_we : bus.c_we;
        addr_d    = grant ? bus.d_addr : bus.c_addr;
        wdata_d   = grant ? bus.d_wdata : bus.c_wdata;
        cnt_d     = '0;
        mem_req_d = 1'b1;
      end
      ST_ACCESS: if (finish) begin
        state_d   = ST_DONE;
        mem_req_d = 1'b0;
        c_ack_d   = owner_q == PORT_CORE;
        d_ack_d   = owner_q == PORT_DMA;
        c_err_d   = (owner_q == PORT_CORE) && timeout;
        d_err_d   = (owner_q == PORT_DMA) && timeout;
        c_rdata_d = (owner_q == PORT_CORE) ? fin_rdata : c_rdata_q;
        d_rdata_d = (owner_q == PORT_DMA) ? fin_rdata : d_rdata_q;
      end else begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_CORE;
      last_q    <= PORT_DMA;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      c_ack_q   <= 1'b0;
      c_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      c_ack_q   <= c_ack_d;
      c_err_q   <= c_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
    end
  end
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.c_ack     = c_ack_q;
  assign bus.c_err     = c_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign busy          = state_q != ST_IDLE;
  assign owner         = owner_q;
endmodule
